// File: rtl/load_store_unit.sv
// load_store_unit: initiator side of a word-wide, byte-addressed data memory.
// Takes one load/store request at a time, performs big-endian byte/half
// extraction with sign/zero extension, and uses read-modify-write for
// sub-word stores. Responses return over a valid/ready handshake.
//
// Optional feature: define LSU_ALIGN_CHECK_EN to flag misaligned half/word
// accesses with rspErr; they then skip the memory entirely.
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   reqValid/reqReady                request handshake
//   reqWrite, reqSize, reqUnsigned   request kind
//   reqAddr, reqWdata                byte address, store data (right-aligned)
//   rspValid/rspReady                response handshake
//   rspData, rspErr                  extended load data, misalignment flag
//   memAdr, writeData, memWrite      word-aligned memory cycle
//   readData                         combinational read of word at memAdr
module load_store_unit #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              reqValid,
    output logic              reqReady,
    input  logic              reqWrite,
    input  logic [1:0]        reqSize,
    input  logic              reqUnsigned,
    input  logic [ADDR_W-1:0] reqAddr,
    input  logic [DATA_W-1:0] reqWdata,
    output logic              rspValid,
    input  logic              rspReady,
    output logic [DATA_W-1:0] rspData,
    output logic              rspErr,
    output logic [ADDR_W-1:0] memAdr,
    output logic [DATA_W-1:0] writeData,
    output logic              memWrite,
    input  logic [DATA_W-1:0] readData
);

    typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, RESP} state_t;

    state_t            state, stateD;
    logic [1:0]        sizeQ, sizeD;
    logic              unsQ, unsD;
    logic [1:0]        offQ, offD;
    logic [ADDR_W-1:0] memAdrD;
    logic [DATA_W-1:0] writeDataD, rspDataD;
    logic              memWriteD, rspValidD, rspErrD;
    logic              misalign;

    // Select the addressed byte/half (offset 0 is the most significant lane) and extend.
    function automatic logic [DATA_W-1:0] extract(input logic [DATA_W-1:0] w,
                                                  input logic [1:0] size,
                                                  input logic uns,
                                                  input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        h = off[1] ? w[15:0] : w[31:16];
        if (size[1])      return w;
        else if (size[0]) return uns ? {16'h0000, h} : {{16{h[15]}}, h};
        else              return uns ? {24'h000000, b} : {{24{b[7]}}, b};
    endfunction

    // Replace only the addressed lane of the old word with the right-aligned store data.
    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old,
                                                input logic [DATA_W-1:0] nw,
                                                input logic [1:0] size,
                                                input logic [1:0] off);
        logic [DATA_W-1:0] m;
        m = old;
        if (size[0]) begin
            if (off[1]) m[15:0]  = nw[15:0];
            else        m[31:16] = nw[15:0];
        end else begin
            case (off)
                2'd0:    m[31:24] = nw[7:0];
                2'd1:    m[23:16] = nw[7:0];
                2'd2:    m[15:8]  = nw[7:0];
                default: m[7:0]   = nw[7:0];
            endcase
        end
        return m;
    endfunction

    assign reqReady = rst_n & (state == IDLE);

    // Misalignment detection on the incoming request.
    always_comb begin
`ifdef LSU_ALIGN_CHECK_EN
        misalign = ((reqSize == 2'b01) && reqAddr[0]) ||
                   (reqSize[1] && (reqAddr[1:0] != 2'b00));
`else
        misalign = 1'b0;
`endif
    end

    // Next-state and next-output logic.
    always_comb begin
        stateD     = state;
        sizeD      = sizeQ;
        unsD       = unsQ;
        offD       = offQ;
        memAdrD    = memAdr;
        writeDataD = writeData;
        rspDataD   = rspData;
        rspErrD    = rspErr;
        memWriteD  = 1'b0;
        rspValidD  = 1'b0;
        case (state)
            IDLE: begin
                if (reqValid) begin
                    sizeD    = reqSize;
                    unsD     = reqUnsigned;
                    offD     = reqAddr[1:0];
                    memAdrD  = {reqAddr[ADDR_W-1:2], 2'b00};
                    rspDataD = '0;
                    rspErrD  = misalign;
                    if (reqWrite) writeDataD = reqWdata;
                    if (misalign) begin
                        stateD    = RESP;
                        rspValidD = 1'b1;
                    end else if (!reqWrite) begin
                        stateD = LOAD;
                    end else if (reqSize[1]) begin
                        stateD    = WRITE;
                        memWriteD = 1'b1;
                    end else begin
                        stateD = RMW_RD;
                    end
                end
            end
            LOAD: begin
                rspDataD  = extract(readData, sizeQ, unsQ, offQ);
                stateD    = RESP;
                rspValidD = 1'b1;
            end
            RMW_RD: begin
                writeDataD = merge(readData, writeData, sizeQ, offQ);
                stateD     = WRITE;
                memWriteD  = 1'b1;
            end
            WRITE: begin
                stateD    = RESP;
                rspValidD = 1'b1;
            end
            RESP: begin
                if (rspReady) stateD = IDLE;
                else          rspValidD = 1'b1;
            end
            default: stateD = IDLE;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sizeQ     <= 2'b00;
            unsQ      <= 1'b0;
            offQ      <= 2'b00;
            memAdr    <= '0;
            writeData <= '0;
            rspData   <= '0;
            rspErr    <= 1'b0;
            memWrite  <= 1'b0;
            rspValid  <= 1'b0;
        end else begin
            state     <= stateD;
            sizeQ     <= sizeD;
            unsQ      <= unsD;
            offQ      <= offD;
            memAdr    <= memAdrD;
            writeData <= writeDataD;
            rspData   <= rspDataD;
            rspErr    <= rspErrD;
            memWrite  <= memWriteD;
            rspValid  <= rspValidD;
        end
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory interface.
- Accepts one load/store request at a time from the CPU datapath.
- Issues word-aligned read/write cycles to the byte-addressed, word-wide data memory.
- Performs byte/halfword extraction with sign/zero extension, and read-modify-write for sub-word stores.
- Returns a response to the CPU through a valid/ready handshake.

Parameters:
- ADDR_W, 32, request and memory address width.
- DATA_W, 32, data width; fixed at 32, 4 bytes per word.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- reqValid  input  1  CPU request present.
- reqReady  output  1  unit can accept a request; equals (state==IDLE).
- reqWrite  input  1  1=store, 0=load.
- reqSize  input  2  00=byte, 01=half, 10=word; 11 is treated as word.
- reqUnsigned  input  1  load zero-extends when 1, sign-extends when 0.
- reqAddr  input  32  byte address.
- reqWdata  input  32  store data; byte in [7:0], half in [15:0].
- rspValid  output  1  response available.
- rspReady  input  1  CPU consumes response.
- rspData  output  32  extended load data; 0 for stores and errors.
- rspErr  output  1  misaligned access (only with the optional feature).
- memAdr  output  32  always {addr[31:2],2'b00}.
- writeData  output  32  full word to write.
- memWrite  output  1  write strobe; memory writes on the same rising edge.
- readData  input  32  combinational read of the word at memAdr.

Behaviour:
- Byte order within a word is big-endian: byte offset 0 = readData[31:24], offset 3 = [7:0]. Half at offset 0 = [31:16], offset 2 = [15:0].
- Reset (async, rst_n=0): state=IDLE; memAdr, writeData, rspData = 0; memWrite, rspValid, rspErr = 0. reqReady=0 while rst_n=0, 1 afterwards in IDLE. Reset mid-operation aborts immediately; memWrite drops asynchronously; no partial write is issued after reset release.
- Request fields are registered on acceptance (reqValid && reqReady at a rising edge). Inputs are ignored at all other times.
- FSM states: IDLE, LOAD, RMW_RD, WRITE, RESP.
  - IDLE: accept -> load: LOAD; word store: WRITE; byte/half store: RMW_RD.
  - LOAD: drive memAdr; at the edge, extract and extend the selected bytes from readData into rspData -> RESP.
  - RMW_RD: drive memAdr; at the edge, capture readData and merge store bytes into the held word -> WRITE.
  - WRITE: drive memAdr and writeData, memWrite=1 for exactly this cycle -> RESP.
  - RESP: rspValid=1; rspData/rspErr stable until rspReady=1 at an edge -> IDLE.
- Latency, acceptance edge to first rspValid cycle:
  - Load: 2 cycles.
  - Word store: 2 cycles.
  - Sub-word store: 3 cycles.
- Throughput: one request per response. reqReady=0 from the acceptance cycle until the cycle after the response handshake.
- memWrite is never asserted outside WRITE. memAdr holds its last value in IDLE/RESP.
- Sub-word merge preserves the three (byte) or two (half) untouched bytes exactly.
- rspValid with rspReady held high: RESP lasts exactly one cycle.
- reqValid asserted during RESP is not accepted until IDLE.

Optional Feature:
- Macro LSU_ALIGN_CHECK_EN.
- Defined: a half with addr[0]=1, or a word with addr[1:0]!=0, goes IDLE->RESP directly with rspErr=1 and rspData=0. No memory read and no memWrite occur.
- Undefined: rspErr is tied to 0. Low address bits below the access size are ignored: half uses addr[1], word uses offset 0. The access proceeds normally.

Test Plan:
- Setup: word at 0x100 = 0x8899AABB.
- lb 0x101 -> rspData=0xFFFFFF99. lbu 0x101 -> 0x00000099. Each: rspValid 2 cycles after acceptance, memWrite never high.
- lh 0x102 -> 0xFFFFAABB. lhu 0x100 -> 0x00008899. lw 0x100 -> 0x8899AABB.
- sb 0x103 with reqWdata=0x1234565A -> exactly one memWrite cycle, writeData=0x8899AA5A, rspValid 3 cycles after acceptance. Follow-up lw 0x100 returns 0x8899AA5A.
- sw 0x104 with 0xDEADBEEF -> memWrite one cycle with memAdr=0x104 and writeData=0xDEADBEEF, then rspValid. Hold rspReady=0 for 3 cycles -> rspValid stays 1, reqReady stays 0.
- With LSU_ALIGN_CHECK_EN, lw 0x102 -> rspErr=1, rspData=0, rspValid the cycle after acceptance, no memory access. Without the macro, the same request returns 0x8899AABB.
- Drop rst_n during WRITE of sh 0x100 -> memWrite falls immediately, state IDLE, all outputs 0. After release, memory word unchanged and reqReady=1.
